ysyx_23060025_inst_burst_responder: RTL

- Slave-side model of the instruction-fetch port driven by the icache refill path: the `inst_paddr`/`psel`/`plen`/`psize` request and the `pvalid`/`plast`/`rdata` response.
- Accepts one incrementing burst request, waits a programmable first-beat latency, then returns `plen+1` words from an internal word array with `plast` on the final beat.
- Used as the instruction memory in core-level simulation and as the golden responder for icache verification.

---
 rtl/ysyx_23060025_resp_pkg.sv | 17 +
 rtl/ysyx_23060025_resp_mem.sv | 42 ++++
 rtl/ysyx_23060025_inst_burst_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ysyx_23060025_resp_pkg.sv
// Shared types and constants for the instruction burst responder.
package ysyx_23060025_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_BEAT = 3'd2,
        ST_GAP  = 3'd3,
        ST_ERR  = 3'd4,
        ST_TURN = 3'd5
    } resp_state_e;

    localparam logic [2:0] SIZE_WORD = 3'b010;
    localparam int PLEN_W = 8;
    localparam int LAT_W  = 4;

endpackage

// File: rtl/ysyx_23060025_resp_mem.sv
// Word array with one synchronous read port and one write port.
// The read register doubles as the beat data output and is cleared when no read is issued.
module ysyx_23060025_resp_mem
    import ysyx_23060025_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Array write port; contents survive reset
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register: a same-edge write to the read address yields the old word
    always_ff @(posedge clock) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ysyx_23060025_inst_burst_responder.sv
// Instruction-fetch burst slave: accepts one incrementing burst, waits FIRST_LAT cycles,
// then streams plen+1 words from the array with BEAT_GAP idle cycles between beats.
module ysyx_23060025_inst_burst_responder
    import ysyx_23060025_resp_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h2000_0000,
    parameter int unsigned           FIRST_LAT  = 2,
    parameter int unsigned           BEAT_GAP   = 0,
    parameter string                 INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] in_paddr,
    input  logic                  in_psel,
    input  logic [PLEN_W-1:0]     in_plen,
    input  logic [2:0]            in_psize,
    output logic                  out_pvalid,
    output logic                  out_plast,
    output logic [DATA_WIDTH-1:0] out_prdata,
    output logic                  out_perr,
    input  logic                  bd_we,
    input  logic [DEPTH_LOG2-1:0] bd_waddr,
    input  logic [DATA_WIDTH-1:0] bd_wdata
);

    resp_state_e           state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [PLEN_W-1:0]     left_q, left_d;
    logic                  pvalid_q, pvalid_d;
    logic                  plast_q, plast_d;
    logic                  perr_q, perr_d;
    logic                  rd_en_s;
    logic [ADDR_WIDTH-1:0] word_off_s;
    logic                  legal_s;

    // Only the start address is range-checked; later beats wrap inside the array.
    assign word_off_s = (in_paddr - BASE_ADDR) >> 2;
    assign legal_s    = (in_psize == SIZE_WORD)
                     && (in_paddr[1:0] == 2'b00)
                     && (in_paddr >= BASE_ADDR)
                     && (word_off_s[ADDR_WIDTH-1:DEPTH_LOG2] == '0);

    // State register and registered beat flags
    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            left_q   <= '0;
            pvalid_q <= 1'b0;
            plast_q  <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            left_q   <= left_d;
            pvalid_q <= pvalid_d;
            plast_q  <= plast_d;
            perr_q   <= perr_d;
        end
    end

    // Next-state logic; a beat is read from the array in the BEAT cycle and presented after the edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        left_d   = left_q;
        pvalid_d = 1'b0;
        plast_d  = 1'b0;
        perr_d   = 1'b0;
        rd_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_psel) begin
                    if (legal_s) begin
                        idx_d   = word_off_s[DEPTH_LOG2-1:0];
                        left_d  = in_plen;
                        cnt_d   = '0;
                        state_d = (FIRST_LAT > 0) ? ST_WAIT : ST_BEAT;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_W'(FIRST_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_BEAT;
                end else begin
                    cnt_d = cnt_q + LAT_W'(1);
                end
            end
            ST_BEAT: begin
                rd_en_s  = 1'b1;
                pvalid_d = 1'b1;
                plast_d  = (left_q == '0);
                idx_d    = idx_q + DEPTH_LOG2'(1);
                left_d   = left_q - PLEN_W'(1);
                cnt_d    = '0;
                if (left_q == '0) begin
                    state_d = ST_TURN;
                end else if (BEAT_GAP > 0) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_BEAT;
                end
            end
            ST_GAP: begin
                if (cnt_q == LAT_W'(BEAT_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_BEAT;
                end else begin
                    cnt_d = cnt_q + LAT_W'(1);
                end
            end
            ST_ERR: begin
                pvalid_d = 1'b1;
                plast_d  = 1'b1;
                perr_d   = 1'b1;
                state_d  = ST_TURN;
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    ysyx_23060025_resp_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clock     (clock),
        .rstn      (rstn),
        .rd_en_i   (rd_en_s),
        .rd_addr_i (idx_q),
        .rd_data_o (out_prdata),
        .wr_en_i   (bd_we),
        .wr_addr_i (bd_waddr),
        .wr_data_i (bd_wdata)
    );

    assign out_pvalid = pvalid_q;
    assign out_plast  = plast_q;
    assign out_perr   = perr_q;

endmodule
